hog_axi_mem_responder: RTL and testbench

- AXI4 full-protocol slave with internal memory. Responds to the HOG engine's 512-bit AXI master port in simulation, and in FPGA-local builds it stands in for DDR.
- Serves image fetch read bursts and feature write-back bursts.
- Read and write channels are independent and run concurrently, with one outstanding transaction per direction.
- Storage is a simple dual-port array: one write port, one read port, read-first semantics.

---
 rtl/hog_axi_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_hog_axi_mem_responder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hog_axi_mem_responder.sv
// AXI4 slave backed by an internal simple dual-port memory.
// Stands in for DDR behind the HOG engine's 512-bit master port. The read and
// write channels run independently, each with one outstanding burst.
// Optional build macro: HOG_MEM_RESP_ERR_EN. When defined, non-INCR or
// narrow bursts are answered with SLVERR: writes are dropped and reads return
// zero data.
module hog_axi_mem_responder #(
  parameter int unsigned AXI_AW = 31,
  parameter int unsigned AXI_DW = 512,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned DELAY  = 1
) (
  input  logic                aclk,
  input  logic                arest_n,
  // Write address channel
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [AXI_AW-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic [3:0]          s_axi_awqos,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  // Write data channel
  input  logic [AXI_DW-1:0]   s_axi_wdata,
  input  logic [AXI_DW/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  // Write response channel
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  // Read address channel
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [AXI_AW-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  // Read data channel
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [AXI_DW-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  // Completion pulses
  output logic                wr_done,
  output logic                rd_done
);

  localparam int unsigned NumBytes = AXI_DW / 8;
  localparam int unsigned ByteOffW = $clog2(NumBytes);
  localparam int unsigned Depth    = 1 << MEM_AW;

  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  localparam logic [1:0] StWIdle  = 2'd0;
  localparam logic [1:0] StWData  = 2'd1;
  localparam logic [1:0] StWResp  = 2'd2;

  localparam logic [1:0] StRIdle  = 2'd0;
  localparam logic [1:0] StRFetch = 2'd1;
  localparam logic [1:0] StRData  = 2'd2;

  logic aw_err, ar_err;

`ifdef HOG_MEM_RESP_ERR_EN
  assign aw_err = (s_axi_awburst != 2'b01) || (s_axi_awsize != 3'(ByteOffW));
  assign ar_err = (s_axi_arburst != 2'b01) || (s_axi_arsize != 3'(ByteOffW));
  logic unused_sigs;
  assign unused_sigs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                         s_axi_awaddr, s_axi_araddr, s_axi_wlast, (DELAY != 0)};
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
  logic unused_sigs;
  assign unused_sigs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                         s_axi_awaddr, s_axi_araddr, s_axi_wlast, (DELAY != 0),
                         s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst};
`endif

  // Storage: one write port, one registered read port (read-first).
  logic [AXI_DW-1:0] mem_q [Depth];
  logic              mem_we;
  logic              mem_re;
  logic [MEM_AW-1:0] mem_raddr;
  logic [AXI_DW-1:0] rdata_q;

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  logic [1:0]        wstate_q, wstate_d;
  logic [MEM_AW-1:0] widx_q, widx_d;
  logic [8:0]        wcnt_q, wcnt_d;
  logic [7:0]        wlen_q, wlen_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic              werr_q, werr_d;

  // Write FSM next state; the burst ends on beat awlen+1, wlast is not consulted.
  always_comb begin
    wstate_d = wstate_q;
    widx_d   = widx_q;
    wcnt_d   = wcnt_q;
    wlen_d   = wlen_q;
    wid_d    = wid_q;
    werr_d   = werr_q;
    mem_we   = 1'b0;
    unique case (wstate_q)
      StWIdle: begin
        if (s_axi_awvalid) begin
          wstate_d = StWData;
          widx_d   = s_axi_awaddr[ByteOffW +: MEM_AW];
          wcnt_d   = '0;
          wlen_d   = s_axi_awlen;
          wid_d    = s_axi_awid;
          werr_d   = aw_err;
        end
      end
      StWData: begin
        if (s_axi_wvalid) begin
          mem_we = !werr_q;
          widx_d = widx_q + MEM_AW'(1);
          wcnt_d = wcnt_q + 9'd1;
          if (wcnt_q == {1'b0, wlen_q}) begin
            wstate_d = StWResp;
          end
        end
      end
      StWResp: begin
        if (s_axi_bready) begin
          wstate_d = StWIdle;
        end
      end
      default: wstate_d = StWIdle;
    endcase
  end

  // Write FSM state registers.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      wstate_q <= StWIdle;
      widx_q   <= '0;
      wcnt_q   <= '0;
      wlen_q   <= '0;
      wid_q    <= '0;
      werr_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      widx_q   <= widx_d;
      wcnt_q   <= wcnt_d;
      wlen_q   <= wlen_d;
      wid_q    <= wid_d;
      werr_q   <= werr_d;
    end
  end

  // Byte-masked memory write; contents are deliberately not reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (s_axi_wstrb[i]) begin
          mem_q[widx_q][8*i +: 8] <= s_axi_wdata[8*i +: 8];
        end
      end
    end
  end

  assign s_axi_awready = (wstate_q == StWIdle);
  assign s_axi_wready  = (wstate_q == StWData);
  assign s_axi_bvalid  = (wstate_q == StWResp);
  assign s_axi_bid     = wid_q;
  assign s_axi_bresp   = (s_axi_bvalid && werr_q) ? RespSlvErr : RespOkay;
  assign wr_done       = s_axi_bvalid && s_axi_bready;

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  logic [1:0]        rstate_q, rstate_d;
  logic [MEM_AW-1:0] ridx_q, ridx_d;
  logic [8:0]        rcnt_q, rcnt_d;
  logic [7:0]        rlen_q, rlen_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic              rerr_q, rerr_d;
  logic              r_last_beat;

  assign r_last_beat = (rcnt_q == {1'b0, rlen_q});

  // Read FSM next state; on a non-final handshake the next word is fetched
  // in the same cycle so a continuously ready master sees no bubbles.
  always_comb begin
    rstate_d  = rstate_q;
    ridx_d    = ridx_q;
    rcnt_d    = rcnt_q;
    rlen_d    = rlen_q;
    rid_d     = rid_q;
    rerr_d    = rerr_q;
    mem_re    = 1'b0;
    mem_raddr = ridx_q;
    unique case (rstate_q)
      StRIdle: begin
        if (s_axi_arvalid) begin
          rstate_d = StRFetch;
          ridx_d   = s_axi_araddr[ByteOffW +: MEM_AW];
          rcnt_d   = '0;
          rlen_d   = s_axi_arlen;
          rid_d    = s_axi_arid;
          rerr_d   = ar_err;
        end
      end
      StRFetch: begin
        mem_re   = 1'b1;
        rstate_d = StRData;
      end
      StRData: begin
        if (s_axi_rready) begin
          if (r_last_beat) begin
            rstate_d = StRIdle;
          end else begin
            mem_re    = 1'b1;
            mem_raddr = ridx_q + MEM_AW'(1);
            ridx_d    = ridx_q + MEM_AW'(1);
            rcnt_d    = rcnt_q + 9'd1;
          end
        end
      end
      default: rstate_d = StRIdle;
    endcase
  end

  // Read FSM state registers.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      rstate_q <= StRIdle;
      ridx_q   <= '0;
      rcnt_q   <= '0;
      rlen_q   <= '0;
      rid_q    <= '0;
      rerr_q   <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      ridx_q   <= ridx_d;
      rcnt_q   <= rcnt_d;
      rlen_q   <= rlen_d;
      rid_q    <= rid_d;
      rerr_q   <= rerr_d;
    end
  end

  // Registered memory read; holds while the master stalls.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      rdata_q <= '0;
    end else if (mem_re) begin
      rdata_q <= mem_q[mem_raddr];
    end
  end

  assign s_axi_arready = (rstate_q == StRIdle);
  assign s_axi_rvalid  = (rstate_q == StRData);
  assign s_axi_rlast   = s_axi_rvalid && r_last_beat;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = (s_axi_rvalid && rerr_q) ? RespSlvErr : RespOkay;
  assign s_axi_rdata   = rerr_q ? '0 : rdata_q;
  assign rd_done       = s_axi_rvalid && s_axi_rready && s_axi_rlast;

endmodule

// File: tb/tb_hog_axi_mem_responder.sv
// Self-checking bench for hog_axi_mem_responder: directed scenarios plus
// randomized bursts, checked against a word-array reference memory.
module tb_hog_axi_mem_responder;

  localparam int unsigned AW    = 31;
  localparam int unsigned DW    = 512;
  localparam int unsigned IW    = 4;
  localparam int unsigned MAW   = 12;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned BO    = 6;
  localparam int          DEPTH = 4096;

  logic aclk = 1'b0;
  logic arest_n;

  logic [IW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen;
  logic [2:0]    s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic          s_axi_awlock, s_axi_arlock;
  logic [3:0]    s_axi_awcache, s_axi_arcache, s_axi_awqos, s_axi_arqos;
  logic          s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [NB-1:0] s_axi_wstrb;
  logic          s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic          s_axi_bvalid, s_axi_bready;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic          wr_done, rd_done;

  always #5 aclk = ~aclk;

  hog_axi_mem_responder dut (
    .aclk          (aclk),
    .arest_n       (arest_n),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_awlock  (s_axi_awlock),
    .s_axi_awcache (s_axi_awcache),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awqos   (s_axi_awqos),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bid     (s_axi_bid),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arlock  (s_axi_arlock),
    .s_axi_arcache (s_axi_arcache),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arqos   (s_axi_arqos),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .wr_done       (wr_done),
    .rd_done       (rd_done)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model [DEPTH];  // reference memory, word-indexed
  logic [DW-1:0] wd [256];       // write beats for the next write burst
  logic [NB-1:0] ws [256];
  logic [DW-1:0] rx [256];       // beats captured by the last read burst

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic is_err(input logic [2:0] size, input logic [1:0] burst);
`ifdef HOG_MEM_RESP_ERR_EN
    return (burst != 2'b01) || (size != 3'd6);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [AW-1:0] addr_of(input int idx, input logic scramble);
    logic [AW-1:0] a;
    a = '0;
    if (scramble) a = AW'($urandom());  // upper and byte-offset bits must be ignored
    a[BO +: MAW] = MAW'(idx);
    return a;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [IW-1:0] id,
                           input logic [2:0] size, input logic [1:0] burst);
    int n;
    int base;
    logic err;
    err  = is_err(size, burst);
    base = int'(addr[BO +: MAW]);
    @(negedge aclk);
    s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awid = id; s_axi_awsize = size; s_axi_awburst = burst;
    #1;
    n = 0;
    while (s_axi_awready !== 1'b1 && n < 100) begin @(negedge aclk); #1; n++; end
    chk("aw_ready", DW'(n < 100), DW'(1));
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wd[b]; s_axi_wstrb = ws[b]; s_axi_wlast = (b == len);
      #1;
      n = 0;
      while (s_axi_wready !== 1'b1 && n < 100) begin @(negedge aclk); #1; n++; end
      chk("w_ready", DW'(n < 100), DW'(1));
      @(negedge aclk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    #1;
    chk("b_valid", DW'(s_axi_bvalid), DW'(1));
    chk("b_id", DW'(s_axi_bid), DW'(id));
    chk("b_resp", DW'(s_axi_bresp), err ? DW'(2) : DW'(0));
    chk("wr_done", DW'(wr_done), DW'(1));
    if (!err) begin
      for (int b = 0; b <= len; b++) begin
        for (int k = 0; k < NB; k++) begin
          if (ws[b][k]) model[(base + b) % DEPTH][8*k +: 8] = wd[b][8*k +: 8];
        end
      end
    end
    @(negedge aclk);
    s_axi_bready = 1'b0;
    #1;
    chk("b_clear", DW'(s_axi_bvalid), DW'(0));
    chk("aw_ready_after", DW'(s_axi_awready), DW'(1));
    chk("wr_done_clear", DW'(wr_done), DW'(0));
  endtask

  // mode 0: rready always 1; mode 1: 1,0,0,1 repeating; mode 2: random
  task automatic axi_read(input logic [AW-1:0] addr, input int len, input logic [IW-1:0] id,
                          input logic [2:0] size, input logic [1:0] burst, input int mode);
    logic [DW-1:0] expd [256];
    int n;
    int beat;
    int cyc;
    int base;
    logic err;
    err  = is_err(size, burst);
    base = int'(addr[BO +: MAW]);
    for (int b = 0; b <= len; b++) expd[b] = err ? '0 : model[(base + b) % DEPTH];
    @(negedge aclk);
    s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arid = id; s_axi_arsize = size; s_axi_arburst = burst;
    #1;
    n = 0;
    while (s_axi_arready !== 1'b1 && n < 100) begin @(negedge aclk); #1; n++; end
    chk("ar_ready", DW'(n < 100), DW'(1));
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
    #1;
    chk("r_fetch_gap", DW'(s_axi_rvalid), DW'(0));
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 8 * (len + 1) + 50) begin
      @(negedge aclk);
      case (mode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: s_axi_rready = 1'($urandom_range(1, 0));
      endcase
      #1;
      if (cyc == 0 || mode == 0) chk("r_valid_timing", DW'(s_axi_rvalid), DW'(1));
      if (s_axi_rvalid === 1'b1) begin
        chk("r_data", s_axi_rdata, expd[beat]);
        chk("r_last", DW'(s_axi_rlast), DW'(beat == len));
        chk("r_id", DW'(s_axi_rid), DW'(id));
        chk("r_resp", DW'(s_axi_rresp), err ? DW'(2) : DW'(0));
        chk("rd_done", DW'(rd_done), DW'(s_axi_rready && beat == len));
        if (s_axi_rready) begin
          rx[beat] = s_axi_rdata;
          beat++;
        end
      end
      cyc++;
    end
    chk("r_beats", DW'(beat), DW'(len + 1));
    @(negedge aclk);
    s_axi_rready = 1'b0;
    #1;
    chk("r_clear", DW'(s_axi_rvalid), DW'(0));
    chk("ar_ready_after", DW'(s_axi_arready), DW'(1));
  endtask

  initial begin
    logic [DW-1:0] pat;
    logic [DW-1:0] pword;
    arest_n = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd6;
    s_axi_awburst = 2'b01; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
    s_axi_awqos = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd6;
    s_axi_arburst = 2'b01; s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0;
    s_axi_arqos = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

    // Reset values
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_awready", DW'(s_axi_awready), DW'(1));
    chk("rst_arready", DW'(s_axi_arready), DW'(1));
    chk("rst_wready", DW'(s_axi_wready), DW'(0));
    chk("rst_bvalid", DW'(s_axi_bvalid), DW'(0));
    chk("rst_bid", DW'(s_axi_bid), DW'(0));
    chk("rst_bresp", DW'(s_axi_bresp), DW'(0));
    chk("rst_rvalid", DW'(s_axi_rvalid), DW'(0));
    chk("rst_rlast", DW'(s_axi_rlast), DW'(0));
    chk("rst_rid", DW'(s_axi_rid), DW'(0));
    chk("rst_rresp", DW'(s_axi_rresp), DW'(0));
    chk("rst_rdata", s_axi_rdata, '0);
    chk("rst_wr_done", DW'(wr_done), DW'(0));
    chk("rst_rd_done", DW'(rd_done), DW'(0));
    @(negedge aclk);
    arest_n = 1'b1;

    // Single beat write/read at 0x40
    pat   = {NB{8'hA5}};
    wd[0] = pat; ws[0] = '1;
    axi_write(31'h40, 0, 4'h3, 3'd6, 2'b01);
    axi_read(31'h40, 0, 4'h5, 3'd6, 2'b01, 0);
    chk("single_rdata", rx[0], pat);

    // 16-beat burst at 0x1000, data = beat number
    for (int b = 0; b < 16; b++) begin wd[b] = DW'(b); ws[b] = '1; end
    axi_write(31'h1000, 15, 4'h7, 3'd6, 2'b01);
    axi_read(31'h1000, 15, 4'h8, 3'd6, 2'b01, 0);
    for (int b = 0; b < 16; b++) chk("burst16_rdata", rx[b], DW'(b));

    // Stalled read with rready 1,0,0,1
    axi_read(31'h1000, 15, 4'h9, 3'd6, 2'b01, 1);

    // Partial strobe over an all-ones word
    wd[0] = '1; ws[0] = '1;
    axi_write(addr_of(10, 1'b0), 0, 4'h1, 3'd6, 2'b01);
    wd[0] = '0; ws[0] = NB'(1);
    axi_write(addr_of(10, 1'b0), 0, 4'h1, 3'd6, 2'b01);
    axi_read(addr_of(10, 1'b0), 0, 4'h2, 3'd6, 2'b01, 0);
    pword = '1;
    pword[7:0] = 8'h00;
    chk("partial_strobe", rx[0], pword);

    // Wrap: two beats starting at the last index
    wd[0] = rand_word(); wd[1] = rand_word(); ws[0] = '1; ws[1] = '1;
    axi_write(addr_of(DEPTH - 1, 1'b0), 1, 4'hA, 3'd6, 2'b01);
    axi_read(addr_of(0, 1'b0), 0, 4'hB, 3'd6, 2'b01, 0);
    chk("wrap_index0", rx[0], wd[1]);
    axi_read(addr_of(DEPTH - 1, 1'b0), 1, 4'hB, 3'd6, 2'b01, 2);

    // Concurrent 8-beat write at 0x0 and read at 0x2000
    for (int b = 0; b < 8; b++) begin wd[b] = rand_word(); ws[b] = '1; end
    axi_write(31'h2000, 7, 4'h4, 3'd6, 2'b01);
    for (int b = 0; b < 8; b++) begin wd[b] = rand_word(); ws[b] = '1; end
    fork
      axi_write(31'h0, 7, 4'hC, 3'd6, 2'b01);
      axi_read(31'h2000, 7, 4'hD, 3'd6, 2'b01, 0);
    join
    axi_read(31'h0, 7, 4'hE, 3'd6, 2'b01, 2);

    // FIXED burst: SLVERR/zero data with the error feature, INCR data without
    axi_read(31'h1000, 3, 4'h6, 3'd6, 2'b00, 0);
    for (int b = 0; b < 4; b++) wd[b] = rand_word();
    axi_write(31'h1000, 3, 4'h6, 3'd6, 2'b00);
    axi_read(31'h1000, 3, 4'h6, 3'd6, 2'b01, 0);

    // Reset asserted mid-read
    @(negedge aclk);
    s_axi_arvalid = 1'b1; s_axi_araddr = 31'h1000; s_axi_arlen = 8'd7; s_axi_arid = 4'h1;
    s_axi_arburst = 2'b01; s_axi_arsize = 3'd6;
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
    @(negedge aclk);
    #1;
    chk("mid_read_valid", DW'(s_axi_rvalid), DW'(1));
    arest_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", DW'(s_axi_rvalid), DW'(0));
    chk("rst_mid_arready", DW'(s_axi_arready), DW'(1));
    @(negedge aclk);
    arest_n = 1'b1;
    #1;
    chk("post_rst_rvalid", DW'(s_axi_rvalid), DW'(0));
    axi_read(31'h1000, 7, 4'h2, 3'd6, 2'b01, 0);

    // Randomized bursts
    for (int t = 0; t < 20; t++) begin
      int idx;
      int len;
      idx = int'($urandom_range(DEPTH - 1, 0));
      len = int'($urandom_range(15, 0));
      for (int b = 0; b <= len; b++) begin
        wd[b] = rand_word();
        ws[b] = (t % 3 == 0) ? {rand_word()}[NB-1:0] : '1;
      end
      axi_write(addr_of(idx, 1'b1), len, 4'($urandom()), 3'd6, 2'b01);
      axi_read(addr_of(idx, 1'b1), len, 4'($urandom()), 3'd6, 2'b01, t % 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
